// File: rtl/id_branch_predictor.sv
// Decode-stage branch predictor: BHT of saturating counters + tagged BTB for fetch,
// six-way branch resolve/train in decode. Define BP_PERF_CNT_EN for perf counters.
module id_branch_predictor #(
    parameter int XLEN      = 32,
    parameter int IDX_BITS  = 6,
    parameter int CTR_WIDTH = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      if_pc,
    output logic                 pred_taken,
    output logic [XLEN-1:0]      pred_target,
    input  logic                 id_valid,
    input  logic                 id_stall,
    input  logic [XLEN-1:0]      id_pc,
    input  logic                 id_pred_taken,
    input  logic [2:0]           id_branch_type,
    input  logic [XLEN-1:0]      id_cmp_a,
    input  logic [XLEN-1:0]      id_cmp_b,
    input  logic [XLEN-1:0]      id_target,
    output logic                 redirect,
    output logic [XLEN-1:0]      redirect_pc,
`ifdef BP_PERF_CNT_EN
    output logic                 bht_busy,
    output logic [CNT_WIDTH-1:0] perf_branches,
    output logic [CNT_WIDTH-1:0] perf_mispredicts
`else
    output logic                 bht_busy
`endif
);
    localparam int ENTRIES = 2 ** IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WIDTH'(2 ** (CTR_WIDTH - 1) - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state, stateNext;
    logic [IDX_BITS-1:0]   clrPtr;

    logic                  btbValid  [ENTRIES];
    logic [TAG_W-1:0]      btbTag    [ENTRIES];
    logic [XLEN-1:0]       btbTarget [ENTRIES];
    logic [CTR_WIDTH-1:0]  bhtCtr    [ENTRIES];

    logic [IDX_BITS-1:0]   ifIdx, idIdx;
    logic [TAG_W-1:0]      ifTag, idTag;
    logic                  ifHit, res, isBranch, actualTaken;
    logic                  aNeg, aZero;

    // Clear walks the tables one entry per cycle; RUN is the normal operating state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= CLEAR;
            clrPtr <= '0;
        end else begin
            state  <= stateNext;
            clrPtr <= (state == CLEAR) ? clrPtr + IDX_BITS'(1) : '0;
        end
    end

    always_comb begin
        stateNext = state;
        bht_busy  = 1'b0;
        case (state)
            CLEAR: begin
                bht_busy = 1'b1;
                if (clrPtr == {IDX_BITS{1'b1}}) stateNext = RUN;
            end
            default: stateNext = RUN;
        endcase
    end

    // Fetch-side lookup: reads pre-edge contents, no bypass from this cycle's train.
    assign ifIdx       = if_pc[IDX_BITS+1:2];
    assign ifTag       = if_pc[XLEN-1:IDX_BITS+2];
    assign ifHit       = btbValid[ifIdx] && (btbTag[ifIdx] == ifTag);
    assign pred_taken  = ifHit && bhtCtr[ifIdx][CTR_WIDTH-1] && !bht_busy;
    assign pred_target = pred_taken ? btbTarget[ifIdx] : if_pc + XLEN'(4);

    assign idIdx    = id_pc[IDX_BITS+1:2];
    assign idTag    = id_pc[XLEN-1:IDX_BITS+2];
    assign res      = id_valid && !id_stall && !bht_busy;
    assign isBranch = (id_branch_type != 3'b000);
    assign aNeg     = id_cmp_a[XLEN-1];
    assign aZero    = (id_cmp_a == '0);

    always_comb begin
        actualTaken = 1'b0;
        case (id_branch_type)
            3'b001:  actualTaken = (id_cmp_a == id_cmp_b);
            3'b010:  actualTaken = (id_cmp_a != id_cmp_b);
            3'b011:  actualTaken = aNeg || aZero;
            3'b100:  actualTaken = !aNeg && !aZero;
            3'b101:  actualTaken = aNeg;
            3'b110:  actualTaken = !aNeg;
            default: actualTaken = 1'b0;
        endcase
    end

    assign redirect    = res && (actualTaken != id_pred_taken);
    assign redirect_pc = (res && actualTaken) ? id_target : id_pc + XLEN'(4);

    // Table storage needs no reset: lookups and training are gated until the clear completes.
    always_ff @(posedge clk) begin
        if (bht_busy) begin
            btbValid[clrPtr] <= 1'b0;
            bhtCtr[clrPtr]   <= CTR_WNT;
        end else if (res) begin
            if (isBranch) begin
                if (actualTaken && bhtCtr[idIdx] != CTR_MAX)
                    bhtCtr[idIdx] <= bhtCtr[idIdx] + CTR_WIDTH'(1);
                else if (!actualTaken && bhtCtr[idIdx] != '0)
                    bhtCtr[idIdx] <= bhtCtr[idIdx] - CTR_WIDTH'(1);
            end
            if (actualTaken) begin
                btbValid[idIdx]  <= 1'b1;
                btbTag[idIdx]    <= idTag;
                btbTarget[idIdx] <= id_target;
            end else if (!isBranch && id_pred_taken) begin
                // A non-branch predicted taken means the BTB entry aliased; drop it.
                btbValid[idIdx] <= 1'b0;
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (res && isBranch) perf_branches <= perf_branches + CNT_WIDTH'(1);
            if (redirect)        perf_mispredicts <= perf_mispredicts + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_id_branch_predictor.sv
// Bench for id_branch_predictor: directed vector table, reset/clear timing, and
// randomized traffic against an array-based reference model.
module tb_id_branch_predictor;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc, pred_target, id_pc, id_cmp_a, id_cmp_b, id_target, redirect_pc;
    logic        pred_taken, id_valid, id_stall, id_pred_taken, redirect, bht_busy;
    logic [2:0]  id_branch_type;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branches, perf_mispredicts;
`endif

    id_branch_predictor #(.XLEN(32), .IDX_BITS(6), .CTR_WIDTH(2), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .id_valid(id_valid), .id_stall(id_stall),
        .id_pc(id_pc), .id_pred_taken(id_pred_taken), .id_branch_type(id_branch_type),
        .id_cmp_a(id_cmp_a), .id_cmp_b(id_cmp_b), .id_target(id_target),
        .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef BP_PERF_CNT_EN
        .bht_busy(bht_busy), .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`else
        .bht_busy(bht_busy)
`endif
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          mValid  [64];
    logic [23:0] mTag    [64];
    logic [31:0] mTarget [64];
    int          mCtr    [64];
    int          mBusyLeft = 64;

    function automatic bit mBusy();
        return !reset || mBusyLeft > 0;
    endfunction

    function automatic bit mCond(logic [2:0] bt, logic [31:0] a, logic [31:0] b);
        case (bt)
            3'd1: return a == b;
            3'd2: return a != b;
            3'd3: return $signed(a) <= 0;
            3'd4: return $signed(a) > 0;
            3'd5: return $signed(a) < 0;
            3'd6: return $signed(a) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit mPred(logic [31:0] pc);
        int i = int'(pc[7:2]);
        return !mBusy() && mValid[i] && mTag[i] == pc[31:8] && mCtr[i] >= 2;
    endfunction

    task automatic mUpdate();
        int  i = int'(id_pc[7:2]);
        bit  t = mCond(id_branch_type, id_cmp_a, id_cmp_b);
        if (!reset) begin
            mBusyLeft = 64;
            for (int k = 0; k < 64; k++) begin mValid[k] = 0; mCtr[k] = 1; end
        end else if (mBusyLeft > 0) begin
            mBusyLeft--;
        end else if (id_valid && !id_stall) begin
            if (id_branch_type != 0) mCtr[i] = t ? ((mCtr[i] < 3) ? mCtr[i] + 1 : 3)
                                                 : ((mCtr[i] > 0) ? mCtr[i] - 1 : 0);
            if (t) begin
                mValid[i] = 1; mTag[i] = id_pc[31:8]; mTarget[i] = id_target;
            end else if (id_branch_type == 0 && id_pred_taken) begin
                mValid[i] = 0;
            end
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] ifPc;
        logic        v, st;
        logic [31:0] idPc;
        logic        pt;
        logic [2:0]  bt;
        logic [31:0] a, b, tgt;
        logic        eRd;
        logic [31:0] eRpc;
        logic        ePt;
        logic [31:0] ePtgt;
    } vec_t;

    vec_t tbl[21];

    task automatic idle();
        id_valid = 0; id_stall = 0; id_pred_taken = 0; id_branch_type = 0;
        id_cmp_a = 0; id_cmp_b = 0; id_target = 0;
    endtask

    task automatic waitClear(input int expCycles);
        int cnt = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!bht_busy) break;
            cnt++;
            @(negedge clk);
        end
        chk("busy_cycles", cnt, expCycles);
    endtask

    logic [31:0] pool[6] = '{32'h100, 32'h4100, 32'h200, 32'hFFFF_FFFC, 32'h1FC, 32'h8000_0100};
    logic [31:0] vals[6] = '{32'h0, 32'h5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h7FFF_FFFF};

    initial begin
        reset = 0; if_pc = 32'h100; id_pc = 32'h100; idle();
        // Reset state with a would-be mispredict presented in decode.
        id_valid = 1; id_branch_type = 3'd1; id_cmp_a = 5; id_cmp_b = 5; id_target = 32'h140;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", bht_busy, 1);
        chk("rst_pred_taken", pred_taken, 0);
        chk("rst_pred_target", pred_target, 32'h104);
        chk("rst_redirect", redirect, 0);
        chk("rst_redirect_pc", redirect_pc, 32'h104);
        @(negedge clk);
        reset = 1;
        idle();
        waitClear(64);

        //          ifPc          v st idPc          pt bt  a             b  tgt      eRd eRpc         ePt ePtgt
        tbl[0]  = '{32'h100,      0, 0, 32'h100,      0, 0, 0,            0, 0,       0, 32'h104,     0, 32'h104};
        tbl[1]  = '{32'h100,      1, 0, 32'h100,      0, 1, 5,            5, 32'h140, 1, 32'h140,     0, 32'h104};
        tbl[2]  = '{32'h100,      0, 0, 32'h100,      0, 0, 0,            0, 0,       0, 32'h104,     1, 32'h140};
        tbl[3]  = '{32'h100,      1, 0, 32'h100,      1, 1, 5,            6, 32'h140, 1, 32'h104,     1, 32'h140};
        tbl[4]  = '{32'h100,      1, 0, 32'h100,      0, 1, 5,            6, 32'h140, 0, 32'h104,     0, 32'h104};
        tbl[5]  = '{32'h100,      1, 0, 32'h100,      0, 1, 5,            6, 32'h140, 0, 32'h104,     0, 32'h104};
        tbl[6]  = '{32'h100,      1, 0, 32'h100,      0, 1, 5,            5, 32'h140, 1, 32'h140,     0, 32'h104};
        tbl[7]  = '{32'h100,      1, 0, 32'h100,      0, 1, 5,            5, 32'h140, 1, 32'h140,     0, 32'h104};
        tbl[8]  = '{32'h100,      1, 0, 32'h100,      1, 1, 5,            5, 32'h140, 0, 32'h140,     1, 32'h140};
        tbl[9]  = '{32'h100,      1, 0, 32'h100,      1, 1, 5,            5, 32'h140, 0, 32'h140,     1, 32'h140};
        tbl[10] = '{32'h100,      1, 0, 32'h100,      1, 1, 5,            6, 32'h140, 1, 32'h104,     1, 32'h140};
        tbl[11] = '{32'h100,      0, 0, 32'h100,      0, 0, 0,            0, 0,       0, 32'h104,     1, 32'h140};
        tbl[12] = '{32'h100,      1, 0, 32'h100,      1, 0, 0,            0, 0,       1, 32'h104,     1, 32'h140};
        tbl[13] = '{32'h100,      0, 0, 32'h100,      0, 0, 0,            0, 0,       0, 32'h104,     0, 32'h104};
        tbl[14] = '{32'h200,      1, 1, 32'h200,      0, 5, 32'h8000_0000, 0, 32'h300, 0, 32'h204,     0, 32'h204};
        tbl[15] = '{32'h200,      1, 0, 32'h200,      0, 5, 32'h8000_0000, 0, 32'h300, 1, 32'h300,     0, 32'h204};
        tbl[16] = '{32'h200,      0, 0, 32'h200,      0, 0, 0,            0, 0,       0, 32'h204,     1, 32'h300};
        tbl[17] = '{32'h4200,     0, 0, 32'h200,      0, 0, 0,            0, 0,       0, 32'h204,     0, 32'h4204};
        tbl[18] = '{32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 0, 0, 0,           0, 0,       0, 32'h0,       0, 32'h0};
        tbl[19] = '{32'h104,      1, 0, 32'h300,      0, 3, 0,            0, 32'h500, 1, 32'h500,     0, 32'h108};
        tbl[20] = '{32'h104,      1, 0, 32'h300,      1, 4, 0,            0, 32'h500, 1, 32'h304,     0, 32'h108};

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if_pc = tbl[i].ifPc; id_valid = tbl[i].v; id_stall = tbl[i].st; id_pc = tbl[i].idPc;
            id_pred_taken = tbl[i].pt; id_branch_type = tbl[i].bt; id_cmp_a = tbl[i].a;
            id_cmp_b = tbl[i].b; id_target = tbl[i].tgt;
            #1;
            chk($sformatf("vec%0d_redirect", i), redirect, tbl[i].eRd);
            chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, tbl[i].eRpc);
            chk($sformatf("vec%0d_pred_taken", i), pred_taken, tbl[i].ePt);
            chk($sformatf("vec%0d_pred_target", i), pred_target, tbl[i].ePtgt);
        end

        // Reset mid-clear restarts from entry 0: busy for a full 64 cycles again.
        @(negedge clk); idle(); reset = 0;
        @(negedge clk); reset = 1;
        repeat (10) @(negedge clk);
        reset = 0;
        @(negedge clk); reset = 1;
        waitClear(64);

`ifdef BP_PERF_CNT_EN
        // Three branches, two mispredicts.
        @(negedge clk); id_pc = 32'h180; id_valid = 1; id_target = 32'h1C0;
        id_branch_type = 3'd1; id_cmp_a = 1; id_cmp_b = 1; id_pred_taken = 0;
        @(negedge clk); id_branch_type = 3'd2; id_pred_taken = 0;
        @(negedge clk); id_branch_type = 3'd6; id_cmp_a = 0; id_pred_taken = 0;
        @(negedge clk); idle(); #1;
        chk("perf_branches", perf_branches, 3);
        chk("perf_mispredicts", perf_mispredicts, 2);
        reset = 0; #1;
        chk("perf_branches_rst", perf_branches, 0);
        chk("perf_mispredicts_rst", perf_mispredicts, 0);
        @(negedge clk); reset = 1;
`endif

        // Randomized traffic against the model; starts and mid-run with a reset.
        for (int c = 0; c < 1500; c++) begin
            bit ePt;
            bit busyE, resE, tE;
            @(negedge clk);
            reset = !((c < 2) || (c >= 600 && c < 603));
            if_pc = pool[$urandom_range(0, 5)];
            id_pc = pool[$urandom_range(0, 5)];
            id_valid = ($urandom_range(0, 9) < 8);
            id_stall = ($urandom_range(0, 4) == 0);
            id_branch_type = 3'($urandom_range(0, 6));
            id_cmp_a = vals[$urandom_range(0, 5)];
            id_cmp_b = vals[$urandom_range(0, 5)];
            id_target = pool[$urandom_range(0, 5)] + 32'h40;
            id_pred_taken = $urandom_range(0, 1) ? mPred(id_pc) : 1'($urandom_range(0, 1));
            #1;
            busyE = mBusy();
            resE  = id_valid && !id_stall && !busyE;
            tE    = mCond(id_branch_type, id_cmp_a, id_cmp_b);
            ePt   = mPred(if_pc);
            chk("rnd_busy", bht_busy, busyE);
            chk("rnd_pred_taken", pred_taken, ePt);
            chk("rnd_pred_target", pred_target,
                ePt ? mTarget[int'(if_pc[7:2])] : if_pc + 32'd4);
            chk("rnd_redirect", redirect, resE && (tE != id_pred_taken));
            chk("rnd_redirect_pc", redirect_pc, (resE && tE) ? id_target : id_pc + 32'd4);
            @(posedge clk);
            mUpdate();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/id_branch_predictor.md
Name: id_branch_predictor

Overview:
- Parametrised successor to the decode-stage branch resolution logic.
- Fetch side: predicts direction and target each cycle using a direct-mapped branch history table of saturating counters plus a tagged branch target buffer.
- Decode side: resolves branches with the same six-way condition set, trains the tables, and raises a one-cycle redirect on misprediction so the hazard unit can flush IF/ID.

Parameters:
- XLEN, 32, datapath and PC width.
- IDX_BITS, 6, log2 of table entries; 2**IDX_BITS entries in both BHT and BTB.
- CTR_WIDTH, 2, saturating counter width; must be >= 1.
- CNT_WIDTH, 32, width of performance counters (optional feature only).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_pc  input  XLEN  PC being fetched this cycle.
- pred_taken  output  1  fetch-side prediction; combinational from if_pc.
- pred_target  output  XLEN  predicted target; equals if_pc+4 when pred_taken=0.
- id_valid  input  1  IF/ID holds a real instruction (not a bubble).
- id_stall  input  1  decode stalled this cycle; suppresses resolve and train.
- id_pc  input  XLEN  PC of the instruction in decode.
- id_pred_taken  input  1  pred_taken carried through IF/ID.
- id_branch_type  input  3  001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 000 not a branch.
- id_cmp_a  input  XLEN  forwarded operand A.
- id_cmp_b  input  XLEN  forwarded operand B.
- id_target  input  XLEN  computed branch target.
- redirect  output  1  mispredict; flush IF/ID and load redirect_pc.
- redirect_pc  output  XLEN  correct next PC.
- bht_busy  output  1  high during post-reset table clear.

Behaviour:
- Index = pc[IDX_BITS+1:2]. Tag = pc[XLEN-1:IDX_BITS+2].
- Lookup:
  - hit = btb_valid[idx] && tag match.
  - pred_taken = hit && counter MSB && !bht_busy.
  - pred_target = btb_target[idx] when pred_taken, else if_pc+4.
  - Reads return pre-edge table contents; no write-to-read bypass. A same-cycle update to the same index is seen on the next cycle.
- Resolve, active when res = id_valid && !id_stall && !bht_busy:
  - actual_taken = condition selected by id_branch_type. Compares are signed on bit XLEN-1; beq/bne use full equality.
  - Type 000 gives actual_taken=0.
  - redirect = res && (actual_taken != id_pred_taken). This is combinational in the same cycle, so a flush can squash the instruction in IF.
  - redirect_pc = id_target if actual_taken, else id_pc+4. All arithmetic is modulo 2**XLEN; id_pc+4 wraps at 0xFFFFFFFC -> 0.
- Train, on res with the update taking effect at the next edge:
  - Branch type != 000: counter +1 if actual_taken, -1 otherwise; saturate at 0 and 2**CTR_WIDTH-1.
  - If actual_taken: write btb_valid=1, the tag, and btb_target=id_target.
  - Type 000 with id_pred_taken=1 (alias false hit): clear btb_valid[idx]; counter unchanged.
  - Type 000 with id_pred_taken=0: no table write.
- Clear state machine, states CLEAR and RUN:
  - Asynchronous reset (reset=0) forces CLEAR, clear pointer 0, bht_busy=1, redirect=0.
  - CLEAR writes one entry per cycle: valid=0 and counter=2**(CTR_WIDTH-1)-1 (weakly not-taken).
  - CLEAR lasts 2**IDX_BITS cycles after reset deasserts, then moves to RUN with bht_busy=0. Pointer wraps to 0.
  - Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from entry 0.
- Reset values:
  - pred_taken=0, pred_target=if_pc+4, redirect=0, redirect_pc=id_pc+4.
  - bht_busy=1, perf counters=0.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- When defined, adds outputs perf_branches[CNT_WIDTH] and perf_mispredicts[CNT_WIDTH].
  - perf_branches increments on res with branch type != 000.
  - perf_mispredicts increments on redirect.
  - Both wrap at 2**CNT_WIDTH and are cleared by reset.
- When undefined, neither port nor counters exist; all other behaviour is identical.

Test Plan:
- Reset release -> bht_busy=1 for exactly 64 cycles, then 0; pred_taken=0 for any if_pc throughout.
- beq at id_pc=0x100, a=b=5, id_pred_taken=0, id_target=0x140 -> redirect=1, redirect_pc=0x140 same cycle. Next cycle if_pc=0x100 gives pred_taken=1 (counter 01->10), pred_target=0x140.
- Same branch not taken twice -> first resolve redirect=1, redirect_pc=0x104, counter 10->01. Second resolve with pred 0 gives no redirect, counter 01->00. A third not-taken stays 00 (saturation).
- Alias: train 0x100 taken, then a non-branch at 0x100 with id_pred_taken=1 -> redirect=1, redirect_pc=0x104, entry invalidated, next lookup pred_taken=0.
- id_stall=1 with a mispredicting bltz (a=0x80000000) -> redirect=0 and no table change. Deasserting stall -> redirect=1.
- BP_PERF_CNT_EN: 3 branches with 2 mispredicts -> perf_branches=3, perf_mispredicts=2. Reset mid-run -> both 0.
